// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Package  : shift_pkg
// Shared widths, port indices and state encoding for the shifter arbiter.
// Revision : 1.0
// ============================================================================
package shift_pkg;

    localparam int XLEN     = 32;
    localparam int SHAMT_W  = 5;
    localparam int PORT_EXE = 0;
    localparam int PORT_LSU = 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter_shifter
// Combinational barrel shifter: SLL, SRL and SRA on a shared datapath.
// Revision : 1.0
// ============================================================================
module shift_arbiter_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   ra,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               signd,
    input  logic               lsl,
    output logic [WIDTH-1:0]   result
);

    always_comb begin
        result = '0;
        if (lsl) begin
            result = ra << shamt;
        end else if (signd) begin
            result = WIDTH'($signed(ra) >>> shamt);
        end else begin
            result = ra >> shamt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Round-robin sharing of one shifter between execute and load/store ports.
// Revision : 1.0
// ============================================================================
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int XLEN   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req_valid,
    output logic [NPORTS-1:0]         req_ready,
    input  logic [NPORTS*XLEN-1:0]    req_ra,
    input  logic [NPORTS*SHAMT_W-1:0] req_rb,
    input  logic [NPORTS-1:0]         req_signd,
    input  logic [NPORTS-1:0]         req_lsl,
    output logic [NPORTS-1:0]         resp_valid,
    input  logic [NPORTS-1:0]         resp_ready,
    output logic [XLEN-1:0]           resp_data,
    output logic                      busy
);

    state_t            state_q;
    state_t            state_d;
    logic              out_owner;
    logic [XLEN-1:0]   out_data;
    logic              last;

    logic              out_valid;
    logic              free;
    logic              any_req;
    logic              grant_port;
    logic              grant_fire;

    logic [XLEN-1:0]    sel_ra;
    logic [SHAMT_W-1:0] sel_rb;
    logic               sel_signd;
    logic               sel_lsl;
    logic [XLEN-1:0]    shift_result;

    assign out_valid = (state_q == ST_FULL);
    assign free      = !out_valid || resp_ready[out_owner];
    assign any_req   = |req_valid;

    // Round-robin: on contention the port that did not win last time goes.
    always_comb begin
        grant_port = 1'(PORT_EXE);
        if (&req_valid) begin
            grant_port = ~last;
        end else if (req_valid[PORT_LSU]) begin
            grant_port = 1'(PORT_LSU);
        end
    end

    assign grant_fire = free && any_req;

    always_comb begin
        sel_ra    = req_ra[PORT_EXE*XLEN +: XLEN];
        sel_rb    = req_rb[PORT_EXE*SHAMT_W +: SHAMT_W];
        sel_signd = req_signd[PORT_EXE];
        sel_lsl   = req_lsl[PORT_EXE];
        if (grant_port == 1'(PORT_LSU)) begin
            sel_ra    = req_ra[PORT_LSU*XLEN +: XLEN];
            sel_rb    = req_rb[PORT_LSU*SHAMT_W +: SHAMT_W];
            sel_signd = req_signd[PORT_LSU];
            sel_lsl   = req_lsl[PORT_LSU];
        end
    end

    shift_arbiter_shifter #(
        .WIDTH (XLEN)
    ) u_shifter (
        .ra     (sel_ra),
        .shamt  (sel_rb),
        .signd  (sel_signd),
        .lsl    (sel_lsl),
        .result (shift_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (grant_fire) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!grant_fire && resp_ready[out_owner]) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            out_owner <= 1'b0;
            out_data  <= '0;
            last      <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                out_data  <= shift_result;
                out_owner <= grant_port;
                last      <= grant_port;
            end
        end
    end

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            assign req_ready[p]  = !rst && grant_fire && req_valid[p] && (grant_port == 1'(p));
            assign resp_valid[p] = out_valid && (out_owner == 1'(p));
        end
    endgenerate

    assign resp_data = out_data;
    assign busy      = out_valid;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Scenario bench for shift_arbiter with a queue-based expected-result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_shift_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_ra;
    logic [9:0]  req_rb;
    logic [1:0]  req_signd;
    logic [1:0]  req_lsl;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int checks = 0;
    int passes = 0;

    logic [31:0] ra_a [2];
    logic [4:0]  rb_a [2];
    logic        sg_a [2];
    logic        ls_a [2];
    logic        vl_a [2];

    exp_t sb [$];
    exp_t e;

    shift_arbiter #(.NPORTS(2), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ra     (req_ra),
        .req_rb     (req_rb),
        .req_signd  (req_signd),
        .req_lsl    (req_lsl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference shift built on a 64-bit widened word.
    function automatic logic [31:0] model(logic [31:0] a, logic [4:0] s, logic sg, logic l);
        logic [63:0] w;
        if (l) begin
            w = {32'b0, a} << s;
        end else begin
            w = {{32{sg & a[31]}}, a} >> s;
        end
        return w[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int p = 0; p < 2; p++) begin
            req_valid[p]        = vl_a[p];
            req_ra[p*32 +: 32]  = ra_a[p];
            req_rb[p*5 +: 5]    = rb_a[p];
            req_signd[p]        = sg_a[p];
            req_lsl[p]          = ls_a[p];
        end
    endtask

    task automatic set_req(int p, logic [31:0] a, logic [4:0] s, logic sg, logic l);
        ra_a[p] = a; rb_a[p] = s; sg_a[p] = sg; ls_a[p] = l; vl_a[p] = 1'b1;
        apply();
    endtask

    task automatic idle_all();
        vl_a[0] = 1'b0; vl_a[1] = 1'b0;
        apply();
    endtask

    task automatic push_accepted();
        for (int p = 0; p < 2; p++) begin
            if (req_ready[p] === 1'b1) begin
                sb.push_back('{port: 1'(p), data: model(ra_a[p], rb_a[p], sg_a[p], ls_a[p])});
            end
        end
    endtask

    function automatic exp_t take();
        if (sb.size() != 0) return sb.pop_front();
        return '{port: 1'b1, data: 32'hDEAD_BEEF};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        resp_ready = 2'b11;
        set_req(0, 32'h1234_5678, 5'd3, 1'b0, 1'b1);
        set_req(1, 32'h8765_4321, 5'd7, 1'b1, 1'b0);
        tick(); tick();
        checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else passes++;
        checks++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", resp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (resp_data !== 32'h0) $display("FAIL reset_resp_data: got %h want 00000000", resp_data); else passes++;
        idle_all();
        rst = 1'b0;
        tick();
        sb.delete();
    endtask

    task automatic test_port0_shift();
        resp_ready = 2'b11;
        set_req(0, 32'h0000_0001, 5'd4, 1'b0, 1'b1);
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL p0_req_ready: got %b want 01", req_ready); else passes++;
        push_accepted();
        tick();
        idle_all();
        #1;
        e = take();
        checks++; if (resp_valid !== 2'b01) $display("FAIL p0_resp_valid: got %b want 01", resp_valid); else passes++;
        checks++; if (resp_data !== 32'h0000_0010 || resp_data !== e.data) $display("FAIL p0_resp_data: got %h want 00000010", resp_data); else passes++;
        tick();
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL p0_drain: got valid %b busy %b want 00 0", resp_valid, busy); else passes++;
    endtask

    task automatic test_port1_shift();
        logic [31:0] want [2];
        want[0] = 32'h0800_0000;
        want[1] = 32'hF800_0000;
        resp_ready = 2'b11;
        for (int sg = 1; sg >= 0; sg--) begin
            set_req(1, 32'h8000_0000, 5'd4, 1'(sg), 1'b0);
            #1;
            checks++; if (req_ready !== 2'b10) $display("FAIL p1_req_ready: got %b want 10", req_ready); else passes++;
            push_accepted();
            tick();
            idle_all();
            #1;
            e = take();
            checks++; if (resp_valid !== 2'b10) $display("FAIL p1_resp_valid: got %b want 10", resp_valid); else passes++;
            checks++; if (resp_data !== want[sg] || resp_data !== e.data) $display("FAIL p1_resp_data signd=%0d: got %h want %h", sg, resp_data, want[sg]); else passes++;
            tick();
        end
    endtask

    task automatic test_boundary();
        logic [31:0] a_t [4];
        logic [4:0]  s_t [4];
        logic        g_t [4];
        logic        l_t [4];
        logic [31:0] w_t [4];
        a_t[0] = 32'hFFFF_FFFF; s_t[0] = 5'd31; g_t[0] = 1'b0; l_t[0] = 1'b0; w_t[0] = 32'h0000_0001;
        a_t[1] = 32'hFFFF_FFFF; s_t[1] = 5'd31; g_t[1] = 1'b1; l_t[1] = 1'b0; w_t[1] = 32'hFFFF_FFFF;
        a_t[2] = 32'h0000_0003; s_t[2] = 5'd31; g_t[2] = 1'b0; l_t[2] = 1'b1; w_t[2] = 32'h8000_0000;
        a_t[3] = 32'hA5A5_0F0F; s_t[3] = 5'd0;  g_t[3] = 1'b1; l_t[3] = 1'b0; w_t[3] = 32'hA5A5_0F0F;
        resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            set_req(0, a_t[i], s_t[i], g_t[i], l_t[i]);
            #1;
            push_accepted();
            tick();
            idle_all();
            #1;
            e = take();
            checks++; if (resp_valid !== 2'b01 || resp_data !== w_t[i] || resp_data !== e.data) $display("FAIL boundary_%0d: got valid %b data %h want 01 %h", i, resp_valid, resp_data, w_t[i]); else passes++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] acc;
        logic       exp_g;
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        resp_ready = 2'b11;
        for (int p = 0; p < 2; p++) begin
            set_req(p, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_g = 1'(i % 2);
            checks++; if (req_ready !== (2'b01 << exp_g)) $display("FAIL b2b_grant_%0d: got %b want %b", i, req_ready, 2'b01 << exp_g); else passes++;
            if (i > 0) begin
                e = take();
                checks++; if (resp_valid !== (2'b01 << e.port) || resp_data !== e.data) $display("FAIL b2b_resp_%0d: got valid %b data %h want %b %h", i, resp_valid, resp_data, 2'b01 << e.port, e.data); else passes++;
            end
            acc = req_ready;
            push_accepted();
            tick();
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) set_req(p, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            end
        end
        idle_all();
        #1;
        e = take();
        checks++; if (resp_valid !== (2'b01 << e.port) || resp_data !== e.data) $display("FAIL b2b_last: got valid %b data %h want %b %h", resp_valid, resp_data, 2'b01 << e.port, e.data); else passes++;
        tick();
    endtask

    task automatic test_stall();
        resp_ready = 2'b00;
        set_req(0, 32'h0000_00F0, 5'd2, 1'b0, 1'b1);
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL stall_first_grant: got %b want 01", req_ready); else passes++;
        push_accepted();
        tick();
        idle_all();
        set_req(1, 32'hC000_0000, 5'd1, 1'b1, 1'b0);
        resp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 2'b00) $display("FAIL stall_req_ready_%0d: got %b want 00", i, req_ready); else passes++;
            checks++; if (resp_valid !== 2'b01 || resp_data !== 32'h0000_03C0) $display("FAIL stall_hold_%0d: got valid %b data %h want 01 000003c0", i, resp_valid, resp_data); else passes++;
            tick();
        end
        resp_ready = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b10) $display("FAIL stall_release_grant: got %b want 10", req_ready); else passes++;
        e = take();
        checks++; if (resp_data !== e.data) $display("FAIL stall_release_data: got %h want %h", resp_data, e.data); else passes++;
        push_accepted();
        tick();
        idle_all();
        resp_ready = 2'b11;
        #1;
        e = take();
        checks++; if (resp_valid !== 2'b10 || resp_data !== 32'hE000_0000 || resp_data !== e.data) $display("FAIL stall_p1_result: got valid %b data %h want 10 e0000000", resp_valid, resp_data); else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        resp_ready = 2'b00;
        set_req(1, 32'h0000_FFFF, 5'd8, 1'b0, 1'b1);
        #1;
        push_accepted();
        tick();
        idle_all();
        checks++; if (busy !== 1'b1 || resp_valid !== 2'b10) $display("FAIL midrst_full: got busy %b valid %b want 1 10", busy, resp_valid); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL midrst_cleared: got valid %b busy %b want 00 0", resp_valid, busy); else passes++;
        resp_ready = 2'b11;
        set_req(0, 32'h0000_0005, 5'd1, 1'b0, 1'b1);
        set_req(1, 32'h0000_0005, 5'd1, 1'b0, 1'b0);
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL midrst_first_grant: got %b want 01", req_ready); else passes++;
        push_accepted();
        tick();
        vl_a[0] = 1'b0;
        apply();
        #1;
        e = take();
        checks++; if (resp_valid !== 2'b01 || resp_data !== 32'h0000_000A || resp_data !== e.data) $display("FAIL midrst_result: got valid %b data %h want 01 0000000a", resp_valid, resp_data); else passes++;
        tick();
        idle_all();
        tick();
    endtask

    initial begin
        req_valid = '0; req_ra = '0; req_rb = '0; req_signd = '0; req_lsl = '0;
        resp_ready = '0;
        for (int p = 0; p < 2; p++) begin
            ra_a[p] = '0; rb_a[p] = '0; sg_a[p] = 1'b0; ls_a[p] = 1'b0; vl_a[p] = 1'b0;
        end
        test_reset();
        test_port0_shift();
        test_port1_shift();
        test_boundary();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single combinational shifter datapath between two requesters: port 0 is the execute stage (SLL/SRL/SRA and immediate forms) and port 1 is the load/store alignment path. The block arbitrates round-robin, registers the selected operands into one result stage, and returns the result to the winning port over a valid/ready handshake. It sits between decode/issue and writeback, replacing the direct shifter hookup so the two users never drive it at once.

## Interface
- NPORTS, 2, number of requesters (fixed at 2 in this revision; the parameter is used only for vector widths)
- XLEN, 32, operand width
- clk  in  1  system clock; every register updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NPORTS  per-port request valid
- req_ready  out  NPORTS  per-port request accepted this cycle
- req_ra  in  NPORTS*XLEN  operand to shift, port p at bits [p*XLEN +: XLEN]
- req_rb  in  NPORTS*5  shift amount
- req_signd  in  NPORTS  1 = arithmetic (sign-fill) for right shifts
- req_lsl  in  NPORTS  1 = left shift, 0 = right shift
- resp_valid  out  NPORTS  result valid, one-hot or zero
- resp_ready  in  NPORTS  per-port result consumed
- resp_data  out  XLEN  result, shared by both ports and qualified by resp_valid
- busy  out  1  result register occupied

## Operation
- Shifter semantics: lsl=1 gives ra << rb, zero-filled. lsl=0, signd=0 gives a logical right shift. lsl=0, signd=1 gives an arithmetic right shift. Only rb[4:0] is used.
- Result register: out_valid, out_owner (1 bit), out_data.
- free = !out_valid || resp_ready[out_owner]. A new grant is possible only when free is 1.
- Arbitration is round-robin with a last-grant pointer `last` (reset value 1, so port 0 wins first).
  - Both ports requesting: grant port !last.
  - One port requesting: grant that port.
  - On a grant, last <= granted port.
- req_ready[p] = free && grant==p. Request signals must be held stable while valid and not ready. A deasserted req_valid withdraws the request; it is never latched.
- On a grant: out_data <= shifter(selected operands), out_owner <= granted port, out_valid <= 1.
- On a drain (resp_ready of the owner) with no new grant: out_valid <= 0.
- resp_valid[p] = out_valid && out_owner==p. resp_ready of the non-owner port is ignored.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY → FULL on a grant.
  - FULL → FULL on drain plus a grant, or on a stall.
  - FULL → EMPTY on a drain with no request.

## Timing
- Reset values: resp_valid=0, req_ready=0 while rst is high, busy=0, out_data=0, last=1. A reset mid-operation drops any held result with no response.
- Latency: request accepted in cycle N, resp_valid in cycle N+1.
- Throughput: one result per cycle when the owner holds resp_ready=1, because drain and refill happen in the same cycle.
- Stall: if the owner holds resp_ready=0, resp_data and resp_valid stay stable and both req_ready are 0.
- Simultaneous drain by port 0 and request by port 1: port 1 is granted in the same cycle, and its result appears the next cycle.
- No combinational path exists from req_* to resp_*. req_ready depends combinationally on resp_ready.

## Structure
- Package shift_pkg: XLEN, SHAMT_W=5, and the port index constants PORT_EXE=0 and PORT_LSU=1.
- One sub-module: the existing combinational shifter, instantiated once and fed through the grant mux. The arbiter, result register and handshake logic stay in shift_arbiter.

## Test plan
- Port 0: ra=0x00000001, rb=4, lsl=1 → next cycle resp_valid=01, resp_data=0x00000010.
- Port 1: ra=0x80000000, rb=4, lsl=0, signd=1 → resp_data=0xF8000000. Same stimulus with signd=0 → 0x08000000.
- Both ports valid every cycle, both resp_ready=1 → grants alternate 0,1,0,1 after reset, with one result per cycle and no starvation.
- Port 0 result held with resp_ready=0 for 3 cycles while port 1 requests → req_ready=00 throughout. Port 1 is granted in the cycle resp_ready rises, and its result appears one cycle later.
- rst asserted while FULL → next cycle resp_valid=00 and busy=0. The first post-reset grant goes to port 0 when both ports request.
- rb=31 on ra=0xFFFFFFFF, right shift, signd=0 → 0x00000001. Same with signd=1 → 0xFFFFFFFF.
